// File: rtl/sprite_draw_scheduler.sv
// Arbitrates two sprite requesters onto one VGA plot port: for each grant it
// erases the old sprite box in BG_COLOUR, draws the new box, then acknowledges.
module sprite_draw_scheduler #(
  parameter int         WIDTH     = 20,
  parameter int         HEIGHT    = 14,
  parameter int         X_MAX     = 319,
  parameter int         Y_MAX     = 239,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [8:0] X_INIT_A  = 9'd140,
  parameter logic [8:0] Y_INIT_A  = 9'd100,
  parameter logic [8:0] X_INIT_B  = 9'd40,
  parameter logic [8:0] Y_INIT_B  = 9'd100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [8:0] x_new_a,
  input  logic [8:0] x_new_b,
  input  logic [8:0] y_new_a,
  input  logic [8:0] y_new_b,
  input  logic [2:0] colour_a,
  input  logic [2:0] colour_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [1:0] grant,
  output logic       busy,
  output logic       plot,
  output logic [8:0] x_plot,
  output logic [8:0] y_plot,
  output logic [2:0] colour,
  output logic [1:0] dbg_state
);
  // Handshake: a requester raises req and holds it until it sees the one-cycle
  // ack; it drops req on the edge that samples ack=1. DONE keeps the FSM out of
  // IDLE during the ack cycle so that edge cannot be mistaken for a new request.

  localparam int IW = $clog2(WIDTH + 1);
  localparam int JW = $clog2(HEIGHT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH);
  localparam logic [JW-1:0] J_LAST = JW'(HEIGHT);
  localparam logic [9:0]    X_LIM  = 10'(X_MAX);
  localparam logic [9:0]    Y_LIM  = 10'(Y_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic            sel_b_q, sel_b_d;
  logic            rr_b_q, rr_b_d;
  logic [8:0]      old_xa_q, old_xa_d, old_ya_q, old_ya_d;
  logic [8:0]      old_xb_q, old_xb_d, old_yb_q, old_yb_d;
  logic [8:0]      new_x_q, new_x_d, new_y_q, new_y_d;
  logic [2:0]      col_q, col_d;
  logic [8:0]      erase_x_q, erase_x_d, erase_y_q, erase_y_d;
  logic            plot_q, plot_d;
  logic [8:0]      x_plot_q, x_plot_d, y_plot_q, y_plot_d;
  logic [2:0]      colour_q, colour_d;
  logic            ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic [1:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            last_px;
  logic [8:0]      base_x, base_y;
  logic [9:0]      sum_x, sum_y;
  logic            on_screen;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      sel_b_q   <= 1'b0;
      rr_b_q    <= 1'b0;
      old_xa_q  <= X_INIT_A;
      old_ya_q  <= Y_INIT_A;
      old_xb_q  <= X_INIT_B;
      old_yb_q  <= Y_INIT_B;
      new_x_q   <= '0;
      new_y_q   <= '0;
      col_q     <= '0;
      erase_x_q <= '0;
      erase_y_q <= '0;
      plot_q    <= 1'b0;
      x_plot_q  <= '0;
      y_plot_q  <= '0;
      colour_q  <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      sel_b_q   <= sel_b_d;
      rr_b_q    <= rr_b_d;
      old_xa_q  <= old_xa_d;
      old_ya_q  <= old_ya_d;
      old_xb_q  <= old_xb_d;
      old_yb_q  <= old_yb_d;
      new_x_q   <= new_x_d;
      new_y_q   <= new_y_d;
      col_q     <= col_d;
      erase_x_q <= erase_x_d;
      erase_y_q <= erase_y_d;
      plot_q    <= plot_d;
      x_plot_q  <= x_plot_d;
      y_plot_q  <= y_plot_d;
      colour_q  <= colour_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, scan counters, arbitration and position bookkeeping.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    sel_b_d   = sel_b_q;
    rr_b_d    = rr_b_q;
    old_xa_d  = old_xa_q;
    old_ya_d  = old_ya_q;
    old_xb_d  = old_xb_q;
    old_yb_d  = old_yb_q;
    new_x_d   = new_x_q;
    new_y_d   = new_y_q;
    col_d     = col_q;
    erase_x_d = erase_x_q;
    erase_y_d = erase_y_q;
    last_px   = (i_q == I_LAST) && (j_q == J_LAST);
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // rr_b_q set means A was served last, so B wins a tie.
          sel_b_d   = req_b && (!req_a || rr_b_q);
          new_x_d   = sel_b_d ? x_new_b  : x_new_a;
          new_y_d   = sel_b_d ? y_new_b  : y_new_a;
          col_d     = sel_b_d ? colour_b : colour_a;
          erase_x_d = sel_b_d ? old_xb_q : old_xa_q;
          erase_y_d = sel_b_d ? old_yb_q : old_ya_q;
          i_d       = '0;
          j_d       = '0;
          state_d   = ERASE;
        end
      end
      ERASE, DRAW: begin
        if (last_px) begin
          i_d     = '0;
          j_d     = '0;
          state_d = (state_q == ERASE) ? DRAW : DONE;
        end else if (i_q == I_LAST) begin
          i_d = '0;
          j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      DONE: begin
        rr_b_d  = !sel_b_q;
        state_d = IDLE;
        if (sel_b_q) begin
          old_xb_d = new_x_q;
          old_yb_d = new_y_q;
        end else begin
          old_xa_d = new_x_q;
          old_ya_d = new_y_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so the first erase
  // pixel appears on the cycle right after the grant edge.
  always_comb begin
    base_x    = (state_d == ERASE) ? erase_x_d : new_x_d;
    base_y    = (state_d == ERASE) ? erase_y_d : new_y_d;
    sum_x     = {1'b0, base_x} + 10'(i_d);
    sum_y     = {1'b0, base_y} + 10'(j_d);
    on_screen = (sum_x <= X_LIM) && (sum_y <= Y_LIM);
    plot_d    = ((state_d == ERASE) || (state_d == DRAW)) && on_screen;
    x_plot_d  = plot_d ? sum_x[8:0] : x_plot_q;
    y_plot_d  = plot_d ? sum_y[8:0] : y_plot_q;
    colour_d  = colour_q;
    if (plot_d) colour_d = (state_d == ERASE) ? BG_COLOUR : col_d;
    ack_a_d   = (state_d == DONE) && !sel_b_d;
    ack_b_d   = (state_d == DONE) && sel_b_d;
    busy_d    = (state_d != IDLE);
    grant_d   = 2'b00;
    if (state_d != IDLE) grant_d = sel_b_d ? 2'b10 : 2'b01;
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign plot      = plot_q;
  assign x_plot    = x_plot_q;
  assign y_plot    = y_plot_q;
  assign colour    = colour_q;
  assign dbg_state = state_q;

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Shares the single VGA plot port between two sprite requesters, A and B.
- For each granted request it does two raster passes over the sprite box:
  - erase: paints BG_COLOUR over the sprite's previous position;
  - draw: paints the requester's colour at the new position.
- Then it records the new position as "old" and acknowledges.
- Sits between game-logic FSMs and the VGA adapter's plot/x/y/colour inputs.

Parameters:
- WIDTH, 20: inclusive x extent; box spans x..x+WIDTH, i.e. 21 pixels.
- HEIGHT, 14: inclusive y extent; box spans y..y+HEIGHT, i.e. 15 pixels.
- X_MAX, 319: largest plottable x.
- Y_MAX, 239: largest plottable y.
- BG_COLOUR, 3'b000: erase colour.
- X_INIT_A / Y_INIT_A, 140 / 100: old position of A after reset.
- X_INIT_B / Y_INIT_B, 40 / 100: old position of B after reset.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low.
- req_a, req_b  in  1  redraw request; held high until the matching ack.
- x_new_a, x_new_b  in  9  new sprite x.
- y_new_a, y_new_b  in  9  new sprite y.
- colour_a, colour_b  in  3  sprite draw colour.
- ack_a, ack_b  out  1  one-cycle pulse when that requester's redraw completes.
- grant  out  2  one-hot {B,A}; identifies the requester being served.
- busy  out  1  high in any state other than IDLE.
- plot  out  1  pixel write strobe.
- x_plot  out  9  pixel x.
- y_plot  out  9  pixel y.
- colour  out  3  pixel colour.

Behaviour:
- Register and reset rules
  - Reset is synchronous, active-low; clock is `clock`.
  - All outputs are registered.
  - Reset values: plot=0, x_plot=0, y_plot=0, colour=0, ack_a=ack_b=0, grant=00, busy=0.
  - Reset also sets: state=IDLE; old_a=(X_INIT_A,Y_INIT_A); old_b=(X_INIT_B,Y_INIT_B); rr pointer favours A.
  - Reset asserted mid-operation aborts on that edge: no ack, old positions return to their INIT values.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE
  - Exactly one request: grant it.
  - Both requests: grant the requester not served last.
  - On the grant edge, snapshot into working registers:
    - the granted requester's new x, new y and colour;
    - its old position.
  - Later changes to x_new/y_new/colour during the operation are ignored.
  - Set grant and busy, then go to ERASE.
- ERASE
  - Counters i (0..WIDTH) and j (0..HEIGHT) start at 0; one pixel per cycle, x fastest.
  - Pixel = (old_x+i, old_y+j), colour=BG_COLOUR.
  - After i==WIDTH && j==HEIGHT, clear the counters and go to DRAW.
- DRAW
  - Same scan at (new_x+i, new_y+j) with the latched colour.
  - After the last pixel, go to DONE.
- DONE
  - plot=0; pulse the granted ack for exactly one cycle.
  - old_<granted> <= latched new position.
  - rr pointer records the served requester.
  - grant=00, busy=0, then IDLE.
- Latency
  - Request seen in IDLE at cycle 0.
  - Erase plots occupy cycles 1..315; draw plots occupy cycles 316..630.
  - ack at cycle 631; IDLE again at cycle 632.
  - This is fixed at 632 cycles per request, independent of clipping.
- Handshake
  - Requester drops req on the edge at which it samples ack=1.
  - req still high in IDLE is treated as a new request.
  - req dropped mid-operation does not abort: the pass completes and ack still pulses.
- Arithmetic and clipping
  - Sums are computed in 10 bits.
  - A pixel with sum_x>X_MAX or sum_y>Y_MAX gets plot=0 for that cycle.
  - That cycle is still consumed.
  - x_plot/y_plot carry the low 9 bits.
  - No wrap onto the opposite screen edge.
- Scan order and idle outputs
  - An erase pass whose box overlaps the new box is not optimised; both passes always run in full.
  - plot is 0 in IDLE and DONE.
  - x_plot/y_plot/colour hold their last value when plot=0.

Test Plan:
1. Reset, then req_a=1 with new=(150,100), colour_a=3'b100, held until ack → expect:
   - cycle 1: plot=1 at (140,100), colour 000;
   - cycle 315: plot at (160,114);
   - cycle 316: plot at (150,100), colour 100;
   - cycle 630: plot at (170,114);
   - ack_a only at cycle 631.
2. req_a and req_b asserted together after reset → A granted first (grant=01). After ack_a, with both asserting again → B granted (grant=10), then A. No requester serviced twice consecutively while the other waits.
3. B at new=(310,230) → pixels with x>319 or y>239 have plot=0, but ack_b still arrives at cycle 631. A following erase of B starts at (310,230) and clips identically.
4. Change x_new_a from 150 to 200 during the ERASE pass → DRAW still starts at (150,100). A second A request then erases from (150,100).
5. Reset driven low during DRAW at cycle 400 → next cycle plot=0, busy=0, no ack. A new A request erases at (140,100).
6. req_b dropped at cycle 50 of its operation → the operation completes and ack_b pulses at cycle 631. Held req_a after ack_a → a second operation starts at cycle 632.
